// File: rtl/lfsr_pkg.sv
// Shared types, default tap masks and the LFSR next-state function.
package lfsr_pkg;

    typedef enum logic {
        LFSR_FIB = 1'b0,
        LFSR_GAL = 1'b1
    } lfsr_mode_e;

    localparam logic [3:0] TAPS4_FIB = 4'b1100;
    localparam logic [3:0] TAPS4_GAL = 4'b0011;
    localparam logic [7:0] TAPS8_FIB = 8'hB8;

    // One LFSR step computed on a 32-bit container; bits above width are cleared.
    // Fibonacci shifts toward the MSB with the tap parity entering the LSB.
    // Galois shifts toward the MSB and folds TAPS in when the outgoing MSB is set.
    function automatic logic [31:0] next_state(
        input logic [31:0] state,
        input logic [31:0] taps,
        input lfsr_mode_e  mode,
        input int unsigned width
    );
        logic [31:0] mask;
        logic [31:0] shifted;
        logic [31:0] res;
        logic        fb;
        logic        msb;
        mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        shifted = state << 1;
        fb      = ^(state & taps & mask);
        msb     = ((state >> (width - 1)) & 32'd1) != 32'd0;
        if (mode == LFSR_FIB) begin
            res = shifted | {31'd0, fb};
        end else begin
            res = msb ? (shifted ^ taps) : shifted;
        end
        return res & mask;
    endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Control and observation bundle for lfsr_gen.
interface lfsr_gen_if #(
    parameter int WIDTH = 8
);
    logic             En;
    logic             Load;
    logic [WIDTH-1:0] Seed_In;
    logic [WIDTH-1:0] Out;
    logic             Bit_Out;
    logic             Lockup;
    logic             Wrap;
    logic [WIDTH-1:0] Period_Out;

    modport master (
        output En, Load, Seed_In,
        input  Out, Bit_Out, Lockup, Wrap, Period_Out
    );

    modport slave (
        input  En, Load, Seed_In,
        output Out, Bit_Out, Lockup, Wrap, Period_Out
    );
endinterface

// File: rtl/lfsr_period_cnt.sv
// Tracks the start value of the running sequence, counts enabled steps and
// reports the length of each completed period.
module lfsr_period_cnt #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load_stb,
    input  logic [WIDTH-1:0] load_val,
    input  logic             step_stb,
    input  logic [WIDTH-1:0] step_val,
    output logic             wrap,
    output logic [WIDTH-1:0] period
);

    logic [WIDTH-1:0] start_reg;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] period_reg;
    logic             wrap_reg;

    assign cnt_inc = cnt_reg + WIDTH'(1);

    // Reset/load restart the measurement; a step landing on the start value closes a period.
    always_ff @(posedge clk) begin
        if (srst) begin
            start_reg  <= SEED;
            cnt_reg    <= '0;
            period_reg <= '0;
            wrap_reg   <= 1'b0;
        end else if (load_stb) begin
            start_reg <= load_val;
            cnt_reg   <= '0;
            wrap_reg  <= 1'b0;
        end else if (step_stb) begin
            if (step_val == start_reg) begin
                period_reg <= cnt_inc;
                cnt_reg    <= '0;
                wrap_reg   <= 1'b1;
            end else begin
                cnt_reg  <= cnt_inc;
                wrap_reg <= 1'b0;
            end
        end else begin
            wrap_reg <= 1'b0;
        end
    end

    assign wrap   = wrap_reg;
    assign period = period_reg;

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with seed load, all-zero substitution and period measurement.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS8_FIB),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int               MODE  = 0
) (
    input  logic       Clk,
    input  logic       Rst,
    lfsr_gen_if.slave  bus
);

    localparam lfsr_mode_e MODE_E = (MODE == 1) ? LFSR_GAL : LFSR_FIB;

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "lfsr_gen: WIDTH must be in 3..32");
    end
    if (SEED == '0) begin : g_bad_seed
        $fatal(1, "lfsr_gen: SEED must be non-zero");
    end

    logic [WIDTH-1:0] state_reg;
    logic [WIDTH-1:0] state_next;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_val;
    logic             lockup_reg;
    logic             lockup_next;
    logic             load_zero;
    logic             step_stb;
    logic             wrap;
    logic [WIDTH-1:0] period;

    assign step_val  = WIDTH'(next_state(32'(state_reg), 32'(TAPS), MODE_E, WIDTH));
    assign load_zero = (bus.Seed_In == '0);
    // An all-zero seed would lock the register up, so SEED stands in for it.
    assign load_val  = load_zero ? SEED : bus.Seed_In;
    assign step_stb  = bus.En & ~bus.Load;

    // Load beats step beats hold; Lockup flags only a substituted load.
    always_comb begin
        state_next  = state_reg;
        lockup_next = 1'b0;
        if (bus.Load) begin
            state_next  = load_val;
            lockup_next = load_zero;
        end else if (bus.En) begin
            state_next = step_val;
        end
    end

    // State and Lockup registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg  <= SEED;
            lockup_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            lockup_reg <= lockup_next;
        end
    end

    lfsr_period_cnt #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_period_cnt (
        .clk      (Clk),
        .srst     (Rst),
        .load_stb (bus.Load),
        .load_val (load_val),
        .step_stb (step_stb),
        .step_val (step_val),
        .wrap     (wrap),
        .period   (period)
    );

    assign bus.Out        = state_reg;
    assign bus.Bit_Out    = state_reg[WIDTH-1];
    assign bus.Lockup     = lockup_reg;
    assign bus.Wrap       = wrap;
    assign bus.Period_Out = period;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: legacy, Fibonacci, Galois, load, gaps, reset and wide configs.
module tb_lfsr_gen;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lfsr_gen_if #(.WIDTH(4))  leg_if ();
    lfsr_gen_if #(.WIDTH(4))  fib_if ();
    lfsr_gen_if #(.WIDTH(4))  gal_if ();
    lfsr_gen_if #(.WIDTH(16)) wide_if ();

    lfsr_gen #(.WIDTH(4), .TAPS(4'b1010), .SEED(4'h8), .MODE(0)) dut_leg (
        .Clk(clk), .Rst(rst), .bus(leg_if));
    lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'h1), .MODE(0)) dut_fib (
        .Clk(clk), .Rst(rst), .bus(fib_if));
    lfsr_gen #(.WIDTH(4), .TAPS(4'b0011), .SEED(4'h1), .MODE(1)) dut_gal (
        .Clk(clk), .Rst(rst), .bus(gal_if));
    lfsr_gen #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'hACE1), .MODE(0)) dut_wide (
        .Clk(clk), .Rst(rst), .bus(wide_if));

    // Hand-computed sequences following the seed.
    logic [3:0] leg_seq [6]  = '{4'h1, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};
    logic [3:0] fib_seq [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                                 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    logic [3:0] gal_seq [15] = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
                                 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  idx;
        int  steps;
        bit  done;
        logic e;
        logic [3:0] exp4;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        leg_if.En = 0;  leg_if.Load = 0;  leg_if.Seed_In = '0;
        fib_if.En = 0;  fib_if.Load = 0;  fib_if.Seed_In = '0;
        gal_if.En = 0;  gal_if.Load = 0;  gal_if.Seed_In = '0;
        wide_if.En = 0; wide_if.Load = 0; wide_if.Seed_In = '0;
        tick();
        tick();

        // Reset state
        check("rst_leg_out", leg_if.Out, 4'h8);
        check("rst_fib_out", fib_if.Out, 4'h1);
        check("rst_gal_out", gal_if.Out, 4'h1);
        check("rst_wide_out", wide_if.Out, 16'hACE1);
        check("rst_leg_period", leg_if.Period_Out, 0);
        check("rst_leg_wrap", leg_if.Wrap, 0);
        check("rst_leg_lockup", leg_if.Lockup, 0);
        check("rst_leg_bit", leg_if.Bit_Out, 1);

        rst = 1'b0;

        // Legacy equivalence
        leg_if.En = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("leg_out[%0d]", i), leg_if.Out, leg_seq[i]);
            check($sformatf("leg_wrap[%0d]", i), leg_if.Wrap, (i == 5) ? 1 : 0);
            check($sformatf("leg_period[%0d]", i), leg_if.Period_Out, (i == 5) ? 6 : 0);
        end
        leg_if.En = 0;
        tick();
        check("leg_hold_out", leg_if.Out, 4'h8);
        check("leg_hold_wrap", leg_if.Wrap, 0);
        check("leg_hold_period", leg_if.Period_Out, 6);

        // Maximal Fibonacci and Galois, run side by side
        fib_if.En = 1;
        gal_if.En = 1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("fib_out[%0d]", i), fib_if.Out, fib_seq[i]);
            check($sformatf("fib_bit[%0d]", i), fib_if.Bit_Out, fib_seq[i][3]);
            check($sformatf("fib_wrap[%0d]", i), fib_if.Wrap, (i == 14) ? 1 : 0);
            check($sformatf("gal_out[%0d]", i), gal_if.Out, gal_seq[i]);
            check($sformatf("gal_wrap[%0d]", i), gal_if.Wrap, (i == 14) ? 1 : 0);
        end
        check("fib_period", fib_if.Period_Out, 15);
        check("gal_period", gal_if.Period_Out, 15);
        fib_if.En = 0;
        gal_if.En = 0;

        // Load and zero protection
        fib_if.Load = 1; fib_if.Seed_In = 4'h5;
        tick();
        check("load5_out", fib_if.Out, 4'h5);
        check("load5_lockup", fib_if.Lockup, 0);
        check("load5_wrap", fib_if.Wrap, 0);
        check("load5_period", fib_if.Period_Out, 15);
        fib_if.Seed_In = 4'h0;
        tick();
        check("load0_out", fib_if.Out, 4'h1);
        check("load0_lockup", fib_if.Lockup, 1);
        fib_if.Load = 0;
        tick();
        check("load0_lockup_clear", fib_if.Lockup, 0);
        check("load0_hold_out", fib_if.Out, 4'h1);
        fib_if.Load = 1; fib_if.En = 1; fib_if.Seed_In = 4'hA;
        tick();
        check("load_over_en_out", fib_if.Out, 4'hA);
        fib_if.Load = 0;
        tick();
        tick();
        tick();
        check("after_load_steps_out", fib_if.Out, 4'h7);

        // Reset mid-sequence overrides Load and En
        rst = 1; fib_if.Load = 1; fib_if.Seed_In = 4'h5;
        tick();
        check("midrst_out", fib_if.Out, 4'h1);
        check("midrst_period", fib_if.Period_Out, 0);
        check("midrst_wrap", fib_if.Wrap, 0);
        check("midrst_lockup", fib_if.Lockup, 0);
        rst = 0; fib_if.Load = 0; fib_if.En = 0;
        tick();

        // Enable gaps: steps are counted, not cycles
        idx = 0;
        for (int c = 0; c < 300 && idx < 15; c++) begin
            e = 1'($urandom_range(0, 1));
            fib_if.En = e;
            tick();
            if (e) idx++;
            exp4 = (idx == 0) ? 4'h1 : fib_seq[idx-1];
            check($sformatf("gap_out[%0d]", c), fib_if.Out, exp4);
            check($sformatf("gap_wrap[%0d]", c), fib_if.Wrap, (e && idx == 15) ? 1 : 0);
        end
        fib_if.En = 0;
        check("gap_steps_done", idx, 15);
        check("gap_period", fib_if.Period_Out, 15);

        // Wide configuration: first Wrap after exactly 65535 steps
        wide_if.En = 1;
        steps = 0;
        done = 0;
        for (int c = 0; c < 70000 && !done; c++) begin
            tick();
            steps++;
            if (wide_if.Wrap) done = 1;
        end
        wide_if.En = 0;
        check("wide_wrap_seen", done, 1);
        check("wide_steps", steps, 65535);
        check("wide_period", wide_if.Period_Out, 16'hFFFF);
        check("wide_out", wide_if.Out, 16'hACE1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
